cpu_status_trace: RTL and testbench

//  Parametrised debug trace buffer for CPU status: PC, opcode, ACC, MR and flags.

---
 rtl/cpu_status_trace.sv | 194 +++++++++++++++++++
 tb/tb_cpu_status_trace.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_status_trace.sv
// cpu_status_trace: DEPTH-entry debug trace of CPU status (PC, opcode, ACC, MR, flags).
// Capture sources: manual (user-sample rising edge) or per retired instruction.
// The ring mode freezes on a halt rising edge so the last DEPTH instructions stay visible.
// Head entry is read out with a valid/ready handshake.
module cpu_status_trace #(
  parameter int PC_W   = 8,
  parameter int OP_W   = 8,
  parameter int DATA_W = 16,
  parameter int FLAG_W = 5,
  parameter int ADDR_W = 4,
  parameter int SEQ_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_start,
  input  logic [1:0]        i_mode,
  input  logic              i_user_sample,
  input  logic              i_instr_retire,
  input  logic              i_halt,
  input  logic              i_clear,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [OP_W-1:0]   i_opcode,
  input  logic [DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0] i_mr,
  input  logic [FLAG_W-1:0] i_flags,
  input  logic              i_rd_ready,
  output logic              o_rd_valid,
  output logic [PC_W-1:0]   o_rd_pc,
  output logic [OP_W-1:0]   o_rd_opcode,
  output logic [DATA_W-1:0] o_rd_acc,
  output logic [DATA_W-1:0] o_rd_mr,
  output logic [FLAG_W-1:0] o_rd_flags,
  output logic [SEQ_W-1:0]  o_rd_seq,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_overflow,
  output logic              o_frozen
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int ENTRY_W = SEQ_W + PC_W + OP_W + 2 * DATA_W + FLAG_W;
  localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [SEQ_W-1:0]  SEQ_ONE  = {{(SEQ_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [ENTRY_W-1:0]  mem_r [DEPTH];
  logic [ADDR_W-1:0]   rd_ptr_r, wr_ptr_r, rd_ptr_s, wr_ptr_s;
  logic [ADDR_W:0]     count_r, count_s;
  logic [SEQ_W-1:0]    seq_r, seq_s;
  logic                overflow_r, overflow_s;
  logic                sample_prev_r, halt_prev_r;
  logic [1:0]          mode_r;
  logic                manual_s, ring_s, cap_s, pop_s, full_s, valid_s, write_s;
  logic [ENTRY_W-1:0]  head_s;

  // Decode the registered mode and derive capture / pop / fullness conditions.
  always_comb begin
    manual_s = 1'b0;
    ring_s   = 1'b0;
    case (mode_r)
      2'b00:   manual_s = 1'b1;
      2'b01:   manual_s = 1'b0;
      2'b10:   ring_s   = 1'b1;
      2'b11:   manual_s = 1'b1;
      default: manual_s = 1'b1;
    endcase
    valid_s = (count_r != {(ADDR_W+1){1'b0}});
    full_s  = (count_r == CNT_FULL);
    if (state_r == ST_ARMED) begin
      cap_s = manual_s ? (i_user_sample & ~sample_prev_r) : i_instr_retire;
    end else begin
      cap_s = 1'b0;
    end
    pop_s = valid_s & i_rd_ready & (state_r != ST_IDLE);
  end

  // Next-state logic; dropping i_cpu_start forces IDLE from anywhere.
  always_comb begin
    state_s = state_r;
    if (!i_cpu_start) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   state_s = ST_ARMED;
        ST_ARMED:  state_s = (ring_s && i_halt && !halt_prev_r) ? ST_FROZEN : ST_ARMED;
        ST_FROZEN: state_s = i_clear ? ST_ARMED : ST_FROZEN;
        default:   state_s = ST_IDLE;
      endcase
    end
  end

  // Buffer bookkeeping: pointers, occupancy, sequence number and sticky overflow.
  always_comb begin
    rd_ptr_s   = rd_ptr_r;
    wr_ptr_s   = wr_ptr_r;
    count_s    = count_r;
    seq_s      = seq_r;
    overflow_s = overflow_r;
    write_s    = 1'b0;
    if (!i_cpu_start || i_clear) begin
      rd_ptr_s   = {ADDR_W{1'b0}};
      wr_ptr_s   = {ADDR_W{1'b0}};
      count_s    = {(ADDR_W+1){1'b0}};
      seq_s      = {SEQ_W{1'b0}};
      overflow_s = 1'b0;
    end else begin
      if (cap_s) begin
        seq_s = seq_r + SEQ_ONE;
      end else begin
        seq_s = seq_r;
      end
      if (cap_s && full_s && !pop_s) begin
        // Full with no space freed: ring mode overwrites the oldest, others drop.
        overflow_s = 1'b1;
        if (ring_s) begin
          write_s  = 1'b1;
          wr_ptr_s = wr_ptr_r + PTR_ONE;
          rd_ptr_s = rd_ptr_r + PTR_ONE;
        end else begin
          write_s  = 1'b0;
        end
      end else begin
        write_s = cap_s;
        if (cap_s) begin
          wr_ptr_s = wr_ptr_r + PTR_ONE;
        end else begin
          wr_ptr_s = wr_ptr_r;
        end
        if (pop_s) begin
          rd_ptr_s = rd_ptr_r + PTR_ONE;
        end else begin
          rd_ptr_s = rd_ptr_r;
        end
        if (cap_s && !pop_s) begin
          count_s = count_r + CNT_ONE;
        end else if (pop_s && !cap_s) begin
          count_s = count_r - CNT_ONE;
        end else begin
          count_s = count_r;
        end
      end
    end
  end

  // Control registers with async reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r       <= ST_IDLE;
      rd_ptr_r      <= {ADDR_W{1'b0}};
      wr_ptr_r      <= {ADDR_W{1'b0}};
      count_r       <= {(ADDR_W+1){1'b0}};
      seq_r         <= {SEQ_W{1'b0}};
      overflow_r    <= 1'b0;
      sample_prev_r <= 1'b0;
      halt_prev_r   <= 1'b0;
      mode_r        <= 2'b00;
    end else begin
      state_r       <= state_s;
      rd_ptr_r      <= rd_ptr_s;
      wr_ptr_r      <= wr_ptr_s;
      count_r       <= count_s;
      seq_r         <= seq_s;
      overflow_r    <= overflow_s;
      sample_prev_r <= i_cpu_start ? i_user_sample : 1'b0;
      halt_prev_r   <= i_cpu_start ? i_halt : 1'b0;
      mode_r        <= i_mode;
    end
  end

  // Trace storage; contents are not reset, only the pointers are.
  always_ff @(posedge i_clk) begin
    if (write_s) begin
      mem_r[wr_ptr_r] <= {seq_r, i_pc, i_opcode, i_acc, i_mr, i_flags};
    end
  end

  assign head_s = valid_s ? mem_r[rd_ptr_r] : {ENTRY_W{1'b0}};

  assign o_rd_valid = valid_s;
  assign {o_rd_seq, o_rd_pc, o_rd_opcode, o_rd_acc, o_rd_mr, o_rd_flags} = head_s;
  assign o_count    = count_r;
  assign o_full     = full_s;
  assign o_overflow = overflow_r;
  assign o_frozen   = (state_r == ST_FROZEN);

endmodule

// File: tb/tb_cpu_status_trace.sv
// Directed testbench for cpu_status_trace with hand-computed expectations.
module tb_cpu_status_trace;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_start, user_sample, instr_retire, halt, clear, rd_ready;
  logic [1:0]  mode;
  logic [7:0]  pc, opcode;
  logic [15:0] acc, mr;
  logic [4:0]  flags;
  logic        rd_valid, full, overflow, frozen;
  logic [7:0]  rd_pc, rd_opcode, rd_seq;
  logic [15:0] rd_acc, rd_mr;
  logic [4:0]  rd_flags;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;

  cpu_status_trace dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cpu_start(cpu_start), .i_mode(mode),
    .i_user_sample(user_sample), .i_instr_retire(instr_retire), .i_halt(halt),
    .i_clear(clear), .i_pc(pc), .i_opcode(opcode), .i_acc(acc), .i_mr(mr),
    .i_flags(flags), .i_rd_ready(rd_ready), .o_rd_valid(rd_valid), .o_rd_pc(rd_pc),
    .o_rd_opcode(rd_opcode), .o_rd_acc(rd_acc), .o_rd_mr(rd_mr), .o_rd_flags(rd_flags),
    .o_rd_seq(rd_seq), .o_count(count), .o_full(full), .o_overflow(overflow),
    .o_frozen(frozen)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input int n);
    for (int i = 0; i < n; i++) begin
      instr_retire = 1'b1;
      tick();
      instr_retire = 1'b0;
    end
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic drain(input string tag, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, " valid"}, 32'(rd_valid), 32'd1);
      check({tag, " seq"}, 32'(rd_seq), 32'((first + i) % 256));
      pop_one();
    end
    check({tag, " empty"}, 32'(count), 32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cpu_start = 1'b0; mode = 2'b00; user_sample = 1'b0;
    instr_retire = 1'b0; halt = 1'b0; clear = 1'b0; rd_ready = 1'b0;
    pc = 8'h00; opcode = 8'h00; acc = 16'h0000; mr = 16'h0000; flags = 5'h00;
    tick(); tick();
    check("rst count", 32'(count), 32'd0);
    check("rst valid", 32'(rd_valid), 32'd0);
    check("rst full", 32'(full), 32'd0);
    check("rst ovf", 32'(overflow), 32'd0);
    check("rst frozen", 32'(frozen), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: manual capture on rising edge of a 5-cycle sample level.
    cpu_start = 1'b1;
    tick(); tick();
    pc = 8'h12; opcode = 8'hA5; acc = 16'h1234; mr = 16'hBEEF; flags = 5'h15;
    user_sample = 1'b1;
    tick();
    check("t1 visible", 32'(rd_valid), 32'd1);
    tick(); tick(); tick(); tick();
    user_sample = 1'b0;
    tick();
    check("t1 count", 32'(count), 32'd1);
    check("t1 pc", 32'(rd_pc), 32'h12);
    check("t1 opcode", 32'(rd_opcode), 32'hA5);
    check("t1 acc", 32'(rd_acc), 32'h1234);
    check("t1 mr", 32'(rd_mr), 32'hBEEF);
    check("t1 flags", 32'(rd_flags), 32'h15);
    check("t1 seq", 32'(rd_seq), 32'd0);
    pop_one();
    check("t1 popped", 32'(rd_valid), 32'd0);

    // 2: per-instruction FIFO fills, then drops.
    mode = 2'b01;
    tick();
    do_clear();
    retire(16);
    check("t2 full16", 32'(full), 32'd1);
    check("t2 ovf16", 32'(overflow), 32'd0);
    retire(1);
    check("t2 ovf17", 32'(overflow), 32'd1);
    retire(3);
    check("t2 count", 32'(count), 32'd16);
    check("t2 head", 32'(rd_seq), 32'd0);
    drain("t2 drain", 0, 16);

    // 5: dropping cpu_start clears the block in one cycle.
    retire(7);
    check("t5 count7", 32'(count), 32'd7);
    check("t5 ovf sticky", 32'(overflow), 32'd1);
    cpu_start = 1'b0;
    tick();
    check("t5 count", 32'(count), 32'd0);
    check("t5 valid", 32'(rd_valid), 32'd0);
    check("t5 ovf", 32'(overflow), 32'd0);
    retire(2);
    check("t5 idle ignores", 32'(count), 32'd0);
    cpu_start = 1'b1;
    tick();

    // 4: full FIFO with simultaneous pop and retire.
    retire(16);
    check("t4 full", 32'(full), 32'd1);
    instr_retire = 1'b1; rd_ready = 1'b1;
    tick();
    instr_retire = 1'b0; rd_ready = 1'b0;
    check("t4 count", 32'(count), 32'd16);
    check("t4 ovf", 32'(overflow), 32'd0);
    drain("t4 drain", 1, 16);

    // 3: ring mode overwrites, halt freezes, drain, clear re-arms.
    mode = 2'b10;
    tick();
    do_clear();
    retire(20);
    check("t3 count", 32'(count), 32'd16);
    check("t3 ovf", 32'(overflow), 32'd1);
    halt = 1'b1;
    tick();
    check("t3 frozen", 32'(frozen), 32'd1);
    drain("t3 drain", 4, 16);
    retire(3);
    check("t3 frozen ignores", 32'(count), 32'd0);
    do_clear();
    check("t3 unfrozen", 32'(frozen), 32'd0);
    retire(1);
    check("t3 seq restart", 32'(rd_seq), 32'd0);
    check("t3 count1", 32'(count), 32'd1);
    halt = 1'b0;

    // 6: async reset while reading, then ready held on empty.
    retire(3);
    rd_ready = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t6 count", 32'(count), 32'd0);
    check("t6 valid", 32'(rd_valid), 32'd0);
    check("t6 seq", 32'(rd_seq), 32'd0);
    check("t6 pc", 32'(rd_pc), 32'd0);
    check("t6 ovf", 32'(overflow), 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("t6 no underflow", 32'(count), 32'd0);
    check("t6 valid idle", 32'(rd_valid), 32'd0);
    check("t6 full", 32'(full), 32'd0);
    rd_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
